// File: rtl/alu2_cmd_pkg.sv
// alu2_cmd_pkg: op encodings and the packed command word shared by the command stage
package alu2_cmd_pkg;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;
    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
    } cmd_t;
endpackage

// File: rtl/ALU_2bit.sv
// ALU_2bit: combinational 2-bit ALU with a 3-bit result (add carries into bit 2, sub wraps mod 8)
module ALU_2bit
    import alu2_cmd_pkg::*;
(
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic [1:0] Op,
    output logic [2:0] Y
);
    // result select; logic ops leave bit 2 clear
    always_comb begin
        Y = (Op == ALU_ADD) ? {1'b0, A} + {1'b0, B} :
            (Op == ALU_SUB) ? {1'b0, A} - {1'b0, B} :
            (Op == ALU_AND) ? {1'b0, A & B} :
                              {1'b0, A | B};
    end
endmodule

// File: rtl/alu2_cmd_fifo.sv
// alu2_cmd_fifo: synchronous FIFO with wrapping pointers and a separate count for full/empty
module alu2_cmd_fifo
    import alu2_cmd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = $bits(cmd_t)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    // storage needs no reset; stale entries are never read while count says empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
    // pointers wrap at the power-of-two depth; count tracks push minus pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/alu2_cmd_stage.sv
// alu2_cmd_stage: buffers {a,b,op} commands, runs the FIFO head through ALU_2bit into a tagged output register
module alu2_cmd_stage
    import alu2_cmd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_a,
    input  logic [1:0]                 in_b,
    input  logic [1:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_y,
    output logic [1:0]                 out_op,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH)+1:0]   occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;
    cmd_t             w_in_cmd;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_issue;
    logic [CW-1:0]    w_count;
    logic [2:0]       w_y;
    logic             r_out_valid;
    logic [2:0]       r_out_y;
    logic [1:0]       r_out_op;
    logic [TAG_W-1:0] r_out_tag;
    logic [TAG_W-1:0] r_tag_cnt;
    assign w_in_cmd  = {in_a, in_b, in_op};
    assign in_ready  = !w_full;
    assign w_push    = in_valid && in_ready;
    assign w_issue   = !w_empty && (!r_out_valid || out_ready);
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_op    = r_out_op;
    assign out_tag   = r_out_tag;
    assign occupancy = OW'(w_count) + OW'(r_out_valid);
    alu2_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_in_cmd),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    ALU_2bit u_alu (
        .A  (w_head.a),
        .B  (w_head.b),
        .Op (w_head.op),
        .Y  (w_y)
    );
    // output register: load on issue, clear valid once taken with nothing behind it, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_op    <= '0;
            r_out_tag   <= '0;
            r_tag_cnt   <= '0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_y;
            r_out_op    <= w_head.op;
            r_out_tag   <= r_tag_cnt;
            r_tag_cnt   <= r_tag_cnt + 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu2_cmd_stage.sv
// tb_alu2_cmd_stage: table vectors, directed corner sequences and a randomized scoreboard run
module tb_alu2_cmd_stage;
    localparam int DEPTH = 2;
    localparam int TAG_W = 4;
    logic                     clk = 0;
    logic                     rst_n = 0;
    logic                     in_valid = 0;
    logic                     in_ready;
    logic [1:0]               in_a = 0;
    logic [1:0]               in_b = 0;
    logic [1:0]               in_op = 0;
    logic                     out_valid;
    logic                     out_ready = 0;
    logic [2:0]               out_y;
    logic [1:0]               out_op;
    logic [TAG_W-1:0]         out_tag;
    logic [$clog2(DEPTH)+1:0] occupancy;

    always #5 clk = ~clk;

    alu2_cmd_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    typedef struct {int y; int op; int tag;} res_t;
    typedef struct {int a; int b; int op; int y;} vec_t;

    res_t       exp_q[$];
    int         acc_cnt = 0;
    int         n_push = 0;
    int         checks = 0;
    int         failures = 0;
    bit         stall = 0;
    int         st_y, st_op, st_tag;

    function automatic int ref_alu(int a, int b, int op);
        case (op)
            0: return a + b;
            1: return (a - b + 8) % 8;
            2: return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle: drive at negedge, check against the model, then account for the coming edge
    task automatic step(input bit v, input int a, input int b, input int op, input bit ordy);
        int ov;
        @(negedge clk);
        in_valid = v;
        in_a = a[1:0];
        in_b = b[1:0];
        in_op = op[1:0];
        out_ready = ordy;
        #1;
        ov = int'(out_valid);
        chk("occupancy", int'(occupancy), exp_q.size());
        chk("in_ready", int'(in_ready), int'((exp_q.size() - ov) < DEPTH));
        if (stall) begin
            chk("stall_valid", ov, 1);
            chk("stall_y", int'(out_y), st_y);
            chk("stall_op", int'(out_op), st_op);
            chk("stall_tag", int'(out_tag), st_tag);
        end
        if (out_valid) begin
            chk("result_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("sb_y", int'(out_y), exp_q[0].y);
                chk("sb_op", int'(out_op), exp_q[0].op);
                chk("sb_tag", int'(out_tag), exp_q[0].tag);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        stall = out_valid && !out_ready;
        st_y = int'(out_y);
        st_op = int'(out_op);
        st_tag = int'(out_tag);
        if (in_valid && in_ready) begin
            exp_q.push_back('{ref_alu(a, b, op), op, acc_cnt % (1 << TAG_W)});
            acc_cnt++;
            n_push++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 0;
        in_valid = 0;
        out_ready = 0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_op", int'(out_op), 0);
        chk("rst_out_tag", int'(out_tag), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        acc_cnt = 0;
        stall = 0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
    endtask

    vec_t tbl[8];
    int   drain_y[3];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{3, 3, 0, 6};
        tbl[1] = '{1, 2, 1, 7};
        tbl[2] = '{2, 3, 2, 2};
        tbl[3] = '{1, 2, 3, 3};
        tbl[4] = '{0, 3, 1, 5};
        tbl[5] = '{0, 0, 0, 0};
        tbl[6] = '{3, 3, 2, 3};
        tbl[7] = '{0, 0, 3, 0};
        drain_y[0] = 1;
        drain_y[1] = 7;
        drain_y[2] = 2;

        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 2, 2, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("pre_reset_occ", int'(occupancy), 2);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1);
            chk("discarded_valid", int'(out_valid), 0);
        end

        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1, tbl[i].a, tbl[i].b, tbl[i].op, 1);
            else step(0, 0, 0, 0, 1);
            if (i < 2) chk("latency_valid", int'(out_valid), 0);
            else begin
                chk("tbl_valid", int'(out_valid), 1);
                chk("tbl_y", int'(out_y), tbl[i-2].y);
                chk("tbl_op", int'(out_op), tbl[i-2].op);
                chk("tbl_tag", int'(out_tag), i - 2);
            end
        end

        do_reset();
        n_push = 0;
        for (int i = 0; i < 6; i++) step(1, i % 4, (i + 1) % 4, i % 4, 0);
        chk("full_accepted", n_push, 3);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_occupancy", int'(occupancy), 3);
        chk("full_hold_y", int'(out_y), 1);
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 0, 0, 1);
            if (j == 1) chk("in_ready_after_pop", int'(in_ready), 1);
            if (j < 3) chk("drain_y", int'(out_y), drain_y[j]);
            else chk("drain_occupancy", int'(occupancy), 0);
        end

        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(i < 20, $urandom_range(3), $urandom_range(3), $urandom_range(3), 1);
            if (i >= 2) chk("tag_seq", int'(out_tag), (i - 2) % 16);
        end

        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(1), $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(1));
        for (int g = 0; g < 40 && exp_q.size() > 0; g++) step(0, 0, 0, 0, 1);
        chk("random_drained", exp_q.size(), 0);
        step(0, 0, 0, 0, 1);
        chk("random_idle_valid", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu2_cmd_stage.md
Name: alu2_cmd_stage

Overview:
Registered command stage wrapped around the existing combinational 2-bit ALU (ALU_2bit).
- Accepts {A, B, Op} commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head into ALU_2bit and captures the 3-bit result in an output register.
- Presents each result downstream with its own valid/ready handshake, a sequence tag and occupancy status.
- Sits between the command source and the result consumer, decoupling both from the ALU's zero-latency path.

Parameters:
- DEPTH, 2, command FIFO entries; power of two, ≥2.
- TAG_W, 4, width of the result sequence tag; wraps modulo 2^TAG_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  stage can accept a command this cycle.
- in_a  in  2  operand A.
- in_b  in  2  operand B.
- in_op  in  2  00 add, 01 sub, 10 AND, 11 OR.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- out_y  out  3  ALU result.
- out_op  out  2  Op that produced out_y.
- out_tag  out  TAG_W  sequence number of the result.
- occupancy  out  $clog2(DEPTH)+2  commands held (FIFO plus output register).

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and count cleared.
  - out_valid=0, out_y=0, out_op=0, out_tag=0, occupancy=0.
  - Internal tag counter set to 0.
  - Reset mid-operation discards all buffered commands and any pending result.
- Accept:
  - A push occurs when in_valid && in_ready.
  - in_ready = !fifo_full and is a registered-state function only, with no combinational path from out_ready.
  - in_valid is ignored while in_ready=0; the FIFO must never overflow.
- Issue:
  - Condition: FIFO non-empty && (!out_valid || out_ready).
  - On issue, pop the head and load out_y = ALU_2bit(head.a, head.b, head.op), out_op = head.op, out_tag = tag counter.
  - Increment the tag counter, wrapping to 0 after 2^TAG_W−1.
- Output register:
  - If out_valid && out_ready and no issue occurs, out_valid←0.
  - If out_valid && !out_ready, out_y/out_op/out_tag stay stable and out_valid stays 1.
- Latency: a command accepted at edge N into an empty stage is written at edge N, issued at edge N+1, and out_valid=1 during the cycle after N+1. With continuous out_ready=1, throughput is 1 result/cycle.
- Simultaneous events:
  - Push and issue in the same cycle are both performed; count is unchanged.
  - A push into a full FIFO cannot occur because in_ready=0, even if an issue frees a slot that cycle (no same-cycle pass-through).
  - Pop when empty never occurs.
- Pointers are log2(DEPTH) bits and wrap naturally; full/empty are derived from a separate count.
- Arithmetic follows ALU_2bit exactly:
  - add is zero-extended to 3 bits (max 3+3=6).
  - sub is modulo 8 (1−2 → 3'b111).
  - AND/OR results are zero-extended in bit 2.
- occupancy = fifo_count + out_valid; max DEPTH+1.

Decomposition:
- Shared package:
  - Op encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - Packed command typedef {a[1:0], b[1:0], op[1:0]}.
- Sub-module alu2_cmd_fifo: a generic synchronous FIFO holding the 6-bit packed command, with push/pop/full/empty/count.
- ALU_2bit is instantiated unchanged; the top level holds only the issue logic, output register and tag counter.

Test Plan:
1. Reset with rst_n=0 mid-stream, holding 2 buffered commands → all outputs 0, in_ready=1 after release, and the discarded commands never appear at the output.
2. out_ready=1; push (3,3,00), (1,2,01), (2,3,10), (1,2,11) back-to-back → out_y 6, 7, 2, 3 with out_op 00, 01, 10, 11 and tags 0..3 on consecutive cycles, first out_valid two edges after the first accept.
3. out_ready=0, DEPTH=2; push continuously → exactly 3 accepted, in_ready=0 afterwards, occupancy=3, and out_y/out_tag held stable.
4. Release out_ready=1 after test 3 → the 3 results drain in order over 3 cycles, in_ready rises the cycle after the first pop, and occupancy returns to 0.
5. Stream 20 commands with TAG_W=4 → out_tag sequence 0..15, 0..3 (wrap verified).
6. Random in_valid/out_ready at 50% → scoreboard matches a reference model in order; no loss or duplication, and no out_y change while out_valid && !out_ready.
